// File: rtl/approx_mult_err_monitor_if.sv
// Purpose : operand/product bus between the error monitor and the multiplier under test.
// Latency : none, plain wires; the product may arrive some fixed number of cycles after the operands.
// Backpressure: none; the monitor knows when the product is valid from its own counter.
// Ports   : op_a, op_b (monitor -> multiplier), dut_c (multiplier -> monitor).
//           master = monitor side, slave = multiplier side.
interface approx_mult_err_monitor_if #(
  parameter int W = 4
);
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [2*W-1:0] dut_c;

  modport master (
    output op_a,
    output op_b,
    input  dut_c
  );

  modport slave (
    input  op_a,
    input  op_b,
    output dut_c
  );
endinterface

// File: rtl/approx_mult_err_monitor.sv
// Purpose : exhaustive self-test sweep of a W x W approximate multiplier, accumulating error metrics.
// Latency : each operand pair is held LATENCY+1 cycles; the sweep takes 2^(2W)*(LATENCY+1) cycles in RUN.
// Backpressure: none; start is ignored while busy, and the multiplier must answer within LATENCY cycles.
// Ports   : clk, rst (sync, active high); start pulse in; busy/done status out;
//           mul (master side of the operand/product bus);
//           err_sum, err_cnt, max_ed, max_a, max_b metric outputs.
module approx_mult_err_monitor #(
  parameter int W       = 4,
  parameter int LATENCY = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  approx_mult_err_monitor_if.master      mul,
  output logic [4*W-1:0]                 err_sum,
  output logic [2*W:0]                   err_cnt,
  output logic [2*W-1:0]                 max_ed,
  output logic [W-1:0]                   max_a,
  output logic [W-1:0]                   max_b
);

  // Width of the per-case hold counter; at least one bit even when LATENCY=0.
  localparam int WW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [WW-1:0]    LAST_WAIT = WW'(LATENCY);
  localparam logic [2*W-1:0]   LAST_IDX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   wait_cnt;
  logic            clear;
  logic            sample;

  // The operand registers double as the sweep index: A is the high half,
  // so B varies fastest.
  logic [2*W-1:0]  idx;
  logic [2*W-1:0]  idx_nxt;
  logic [2*W-1:0]  a_ext;
  logic [2*W-1:0]  b_ext;
  logic [2*W-1:0]  exact;
  logic [2*W-1:0]  ed;
  logic            ed_nz;

  assign idx     = {mul.op_a, mul.op_b};
  assign idx_nxt = idx + {{(2*W-1){1'b0}}, 1'b1};

  // ------------------------------------------------------------------
  // Per-case error arithmetic; only consumed on sample cycles.
  // ------------------------------------------------------------------
  assign a_ext = {{W{1'b0}}, mul.op_a};
  assign b_ext = {{W{1'b0}}, mul.op_b};
  assign exact = a_ext * b_ext;
  // Unsigned magnitude of the difference, never wraps.
  assign ed    = (mul.dut_c >= exact) ? (mul.dut_c - exact) : (exact - mul.dut_c);
  assign ed_nz = |ed;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    sample    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      RUN: begin
        // The product is valid at the edge closing the last hold cycle.
        if (wait_cnt == LAST_WAIT) begin
          sample = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // ------------------------------------------------------------------
  // Operand sequencing and metric accumulation
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mul.op_a <= '0;
      mul.op_b <= '0;
      wait_cnt <= '0;
      err_sum  <= '0;
      err_cnt  <= '0;
      max_ed   <= '0;
      max_a    <= '0;
      max_b    <= '0;
    end else if (clear) begin
      mul.op_a <= '0;
      mul.op_b <= '0;
      wait_cnt <= '0;
      err_sum  <= '0;
      err_cnt  <= '0;
      max_ed   <= '0;
      max_a    <= '0;
      max_b    <= '0;
    end else if (sample) begin
      err_sum  <= err_sum + {{(2*W){1'b0}}, ed};
      err_cnt  <= err_cnt + {{(2*W){1'b0}}, ed_nz};
      // Strictly greater: ties keep the first case in sweep order.
      if (ed > max_ed) begin
        max_ed <= ed;
        max_a  <= mul.op_a;
        max_b  <= mul.op_b;
      end
      wait_cnt <= '0;
      // The final pair (all ones) stays on the bus while in DONE.
      if (idx != LAST_IDX) begin
        mul.op_a <= idx_nxt[2*W-1:W];
        mul.op_b <= idx_nxt[W-1:0];
      end
    end else if (state == RUN) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Purpose : bench for approx_mult_err_monitor; u0 (LATENCY=0) with selectable multiplier
//           behaviours, u2 (LATENCY=2) with an exact two-stage pipelined multiplier.
// Latency : n/a. Backpressure: n/a.
// Ports   : none; clock generated here, interfaces instantiated here.
module tb_approx_mult_err_monitor;

  typedef struct {
    int sum;
    int cnt;
    int mx;
    int ma;
    int mb;
  } met_t;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, start0 = 1'b0;
  logic rst2 = 1'b1, start2 = 1'b0;
  logic busy0, done0, busy2, done2;
  logic [15:0] err_sum0, err_sum2;
  logic [8:0]  err_cnt0, err_cnt2;
  logic [7:0]  max_ed0, max_ed2;
  logic [3:0]  max_a0, max_b0, max_a2, max_b2;

  int mode = 0;       // 0 exact, 1 bit0 forced low, 2 constant zero
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  approx_mult_err_monitor_if #(.W(4)) bus0 ();
  approx_mult_err_monitor_if #(.W(4)) bus2 ();

  approx_mult_err_monitor #(.W(4), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0), .mul(bus0),
    .err_sum(err_sum0), .err_cnt(err_cnt0), .max_ed(max_ed0), .max_a(max_a0), .max_b(max_b0)
  );

  approx_mult_err_monitor #(.W(4), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2), .mul(bus2),
    .err_sum(err_sum2), .err_cnt(err_cnt2), .max_ed(max_ed2), .max_a(max_a2), .max_b(max_b2)
  );

  // ---------------- multiplier behaviours ----------------
  function automatic int mult_model(input int md, input int a, input int b);
    case (md)
      1:       return (a * b) & ~1;
      2:       return 0;
      default: return a * b;
    endcase
  endfunction

  always_comb bus0.dut_c = 8'(mult_model(mode, int'(bus0.op_a), int'(bus0.op_b)));

  logic [7:0] p1, p2;
  always @(posedge clk) begin
    p1 <= 8'(bus2.op_a) * 8'(bus2.op_b);
    p2 <= p1;
  end
  assign bus2.dut_c = p2;

  // ---------------- reference model ----------------
  function automatic met_t sweep_metrics(input int md);
    met_t m;
    m = '{0, 0, 0, 0, 0};
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int d;
        d = mult_model(md, a, b) - a * b;
        if (d < 0) d = -d;
        m.sum += d;
        if (d != 0) m.cnt++;
        if (d > m.mx) begin
          m.mx = d;
          m.ma = a;
          m.mb = b;
        end
      end
    end
    return m;
  endfunction

  int   m_phase[2] = '{PH_IDLE, PH_IDLE};
  int   m_cnt[2]   = '{0, 0};
  met_t m_met[2];
  int   lat[2]     = '{0, 2};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      logic r, s;
      r = (i == 0) ? rst0 : rst2;
      s = (i == 0) ? start0 : start2;
      if (r) begin
        m_phase[i] = PH_IDLE;
        m_cnt[i]   = 0;
      end else if (m_phase[i] == PH_RUN) begin
        m_cnt[i]++;
        if (m_cnt[i] == 256 * (lat[i] + 1)) m_phase[i] = PH_DONE;
      end else if (s) begin
        m_phase[i] = PH_RUN;
        m_cnt[i]   = 0;
        m_met[i]   = sweep_metrics((i == 0) ? mode : 0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input logic bsy, input logic dn,
                            input logic [3:0] a, input logic [3:0] b,
                            input logic [15:0] s, input logic [8:0] c,
                            input logic [7:0] mx, input logic [3:0] ma, input logic [3:0] mb);
    met_t e;
    int ea, eb, ix;
    bit chk_met;
    e = '{0, 0, 0, 0, 0};
    chk_met = 1'b1;
    ea = 0;
    eb = 0;
    if (m_phase[i] == PH_RUN) begin
      ix = m_cnt[i] / (lat[i] + 1);
      ea = ix / 16;
      eb = ix % 16;
      chk_met = (m_cnt[i] == 0);  // cleared at start; partial sums not modelled
    end else if (m_phase[i] == PH_DONE) begin
      e  = m_met[i];
      ea = 15;
      eb = 15;
    end
    chk($sformatf("u%0d_busy", i), 32'(bsy), 32'(m_phase[i] == PH_RUN));
    chk($sformatf("u%0d_done", i), 32'(dn),  32'(m_phase[i] == PH_DONE));
    chk($sformatf("u%0d_op_a", i), 32'(a), 32'(ea));
    chk($sformatf("u%0d_op_b", i), 32'(b), 32'(eb));
    if (chk_met) begin
      chk($sformatf("u%0d_err_sum", i), 32'(s),  32'(e.sum));
      chk($sformatf("u%0d_err_cnt", i), 32'(c),  32'(e.cnt));
      chk($sformatf("u%0d_max_ed", i),  32'(mx), 32'(e.mx));
      chk($sformatf("u%0d_max_a", i),   32'(ma), 32'(e.ma));
      chk($sformatf("u%0d_max_b", i),   32'(mb), 32'(e.mb));
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, busy0, done0, bus0.op_a, bus0.op_b, err_sum0, err_cnt0, max_ed0, max_a0, max_b0);
      check_inst(1, busy2, done2, bus2.op_a, bus2.op_b, err_sum2, err_cnt2, max_ed2, max_a2, max_b2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input string name, output int nbusy);
    int budget;
    nbusy  = 0;
    budget = 2000;
    while (!done0 && budget > 0) begin
      if (busy0) nbusy++;
      @(negedge clk);
      budget--;
    end
    if (!done0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done=%0d required 1", name, done0);
    end
  endtask

  task automatic check_final0(input string name, input int s, input int c,
                              input int mx, input int ma, input int mb);
    chk({name, "_err_sum"}, 32'(err_sum0), 32'(s));
    chk({name, "_err_cnt"}, 32'(err_cnt0), 32'(c));
    chk({name, "_max_ed"},  32'(max_ed0),  32'(mx));
    chk({name, "_max_a"},   32'(max_a0),   32'(ma));
    chk({name, "_max_b"},   32'(max_b0),   32'(mb));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nb0, nb2, budget, t0, t1;
    met_t pm;

    // Pin the model against hand-computed totals.
    pm = sweep_metrics(0);
    chk("model_exact_sum", 32'(pm.sum), 32'd0);
    pm = sweep_metrics(1);
    chk("model_bit0_sum", 32'(pm.sum), 32'd64);
    chk("model_bit0_cnt", 32'(pm.cnt), 32'd64);
    chk("model_bit0_max", 32'(pm.mx),  32'd1);
    pm = sweep_metrics(2);
    chk("model_zero_sum", 32'(pm.sum), 32'd14400);
    chk("model_zero_max_a", 32'(pm.ma), 32'd15);

    // Reset.
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    rst2 = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    check_final0("reset", 0, 0, 0, 0, 0);

    // Exact multiplier on both instances.
    mode   = 0;
    start0 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    nb0 = 0;
    nb2 = 0;
    budget = 1000;
    while (!(done0 && done2) && budget > 0) begin
      if (busy0) nb0++;
      if (busy2) nb2++;
      @(negedge clk);
      budget--;
    end
    chk("exact_busy_cycles", 32'(nb0), 32'd256);
    chk("lat2_busy_cycles", 32'(nb2), 32'd768);
    check_final0("exact", 0, 0, 0, 0, 0);
    chk("lat2_err_sum", 32'(err_sum2), 32'd0);
    chk("lat2_err_cnt", 32'(err_cnt2), 32'd0);
    chk("lat2_max_ed", 32'(max_ed2), 32'd0);

    // Bit 0 forced low.
    mode = 1;
    pulse_start0();
    wait_done0("bit0", nb0);
    check_final0("bit0", 64, 64, 1, 1, 1);

    // Constant zero.
    mode = 2;
    pulse_start0();
    wait_done0("zero", nb0);
    check_final0("zero", 14400, 225, 225, 15, 15);

    // Reset mid-sweep at RUN cycle 100, then restart.
    pulse_start0();
    repeat (99) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    check_final0("abort", 0, 0, 0, 0, 0);
    @(negedge clk);
    pulse_start0();
    wait_done0("restart", nb0);
    chk("restart_err_sum", 32'(err_sum0), 32'd14400);

    // Start pulses during the sweep are ignored.
    mode = 1;
    pulse_start0();
    t0 = cyc;
    repeat (9) @(negedge clk);
    pulse_start0();
    repeat (188) @(negedge clk);
    pulse_start0();
    wait_done0("ignore", nb0);
    t1 = cyc;
    chk("ignore_sweep_len", 32'(t1 - t0), 32'd256);
    check_final0("ignore", 64, 64, 1, 1, 1);

    // start together with rst while in DONE: rst wins.
    start0 = 1'b1;
    rst0   = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    rst0   = 1'b0;
    chk("startrst_busy", 32'(busy0), 32'd0);
    chk("startrst_done", 32'(done0), 32'd0);
    chk("startrst_op_a", 32'(bus0.op_a), 32'd0);
    chk("startrst_op_b", 32'(bus0.op_b), 32'd0);
    check_final0("startrst", 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("idle_hold_busy", 32'(busy0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
